// File: rtl/rs_entry_select.sv
// Reservation-station entry selection: lowest-index free-slot encoder
// plus a handshaked round-robin or fixed-priority grant arbiter.
module rs_entry_select #(
  parameter int unsigned N          = 4,
  parameter bit          RR_ARBITER = 1'b1,
  parameter int unsigned IdxLen     = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [N-1:0]      free_i,
  output logic [IdxLen-1:0] free_idx_o,
  output logic              free_valid_o,
  input  logic [N-1:0]      req_i,
  input  logic              gnt_ready_i,
  output logic              gnt_valid_o,
  output logic [IdxLen-1:0] gnt_idx_o,
  output logic [N-1:0]      req_ready_o
);

  logic [IdxLen-1:0] ptr_q;
  logic [IdxLen-1:0] base;
  logic [IdxLen-1:0] pos;
  logic              hs;

  always_comb begin
    free_idx_o   = '0;
    free_valid_o = |free_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_i[i]) free_idx_o = IdxLen'(i);
    end
  end

  // Scan downward so the smallest offset from base wins; the
  // IdxLen-wide add wraps from N-1 to 0 on its own.
  always_comb begin
    base      = RR_ARBITER ? ptr_q : '0;
    pos       = '0;
    gnt_idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = base + IdxLen'(k);
      if (req_i[pos]) gnt_idx_o = pos;
    end
  end

  assign gnt_valid_o = |req_i;
  assign hs          = gnt_valid_o & gnt_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[gnt_idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (flush_i) begin
      ptr_q <= '0;
    end else if (hs && RR_ARBITER) begin
      ptr_q <= gnt_idx_o + IdxLen'(1);
    end
  end

endmodule

// File: tb/tb_rs_entry_select.sv
// Bench for rs_entry_select: directed plan steps then random traffic,
// checked against a rule-level model of both arbiter flavours.
module tb_rs_entry_select;
  localparam int N  = 4;
  localparam int IL = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, flush, rdy;
  logic [N-1:0]  free, req;

  logic [IL-1:0] free_idx, r_idx, f_idx;
  logic          free_vld, r_vld, f_vld;
  logic [N-1:0]  r_rr, f_rr;
  logic [IL-1:0] f_free_idx;
  logic          f_free_vld;

  int tests = 0;
  int fails = 0;
  int mptr  = 0;

  always #5 clk = ~clk;

  rs_entry_select #(.N(N), .RR_ARBITER(1'b1)) u_rr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .free_i(free), .free_idx_o(free_idx),
    .free_valid_o(free_vld),
    .req_i(req), .gnt_ready_i(rdy),
    .gnt_valid_o(r_vld), .gnt_idx_o(r_idx),
    .req_ready_o(r_rr)
  );

  rs_entry_select #(.N(N), .RR_ARBITER(1'b0)) u_fx (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .free_i(free), .free_idx_o(f_free_idx),
    .free_valid_o(f_free_vld),
    .req_i(req), .gnt_ready_i(rdy),
    .gnt_valid_o(f_vld), .gnt_idx_o(f_idx),
    .req_ready_o(f_rr)
  );

  // first set bit encountered walking up from start, wrapping mod N
  function automatic int pick(logic [N-1:0] v, int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(bit en, int i);
    logic [N-1:0] r;
    r = '0;
    if (en) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic f,
                      input logic [N-1:0] fr,
                      input logic [N-1:0] rq,
                      input logic rd,
                      input int eg, input int efg,
                      input int efr);
    int  g, fg, fi;
    bit  any;
    rst = r; flush = f; free = fr; req = rq; rdy = rd;
    #1;
    fi  = pick(fr, 0);
    any = (rq != '0);
    g   = pick(rq, mptr);
    fg  = pick(rq, 0);
    chk("free_idx", 32'(free_idx), 32'(fi));
    chk("free_vld", 32'(free_vld), 32'(fr != '0));
    chk("fx_free_idx", 32'(f_free_idx), 32'(fi));
    chk("rr_vld", 32'(r_vld), 32'(any));
    chk("rr_idx", 32'(r_idx), 32'(g));
    chk("rr_ready", 32'(r_rr), 32'(onehot(any && rd, g)));
    chk("fx_vld", 32'(f_vld), 32'(any));
    chk("fx_idx", 32'(f_idx), 32'(fg));
    chk("fx_ready", 32'(f_rr), 32'(onehot(any && rd, fg)));
    if (eg >= 0)  chk("dir_rr_idx", 32'(r_idx), 32'(eg));
    if (efg >= 0) chk("dir_fx_idx", 32'(f_idx), 32'(efg));
    if (efr >= 0) chk("dir_free_idx", 32'(free_idx), 32'(efr));
    @(posedge clk);
    if (r || f)         mptr = 0;
    else if (any && rd) mptr = (g + 1) % N;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rdy = 1'b0;
    free = '0; req = '0;
    @(posedge clk);
    #1;
    mptr = 0;
    // free path
    step(0, 0, 4'b1010, 4'b0000, 0, 0, 0, 1);
    step(0, 0, 4'b1000, 4'b0000, 0, 0, 0, 3);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    // fairness
    step(0, 0, 4'b0000, 4'b1111, 1, 0, 0, -1);
    step(0, 0, 4'b0000, 4'b1111, 1, 1, 0, -1);
    step(0, 0, 4'b0000, 4'b1111, 1, 2, 0, -1);
    step(0, 0, 4'b0000, 4'b1111, 1, 3, 0, -1);
    step(0, 0, 4'b0000, 4'b1111, 1, 0, 0, -1);
    // stall
    step(1, 0, 4'b0000, 4'b0000, 0, -1, -1, -1);
    step(0, 0, 4'b0000, 4'b0110, 0, 1, 1, -1);
    step(0, 0, 4'b0000, 4'b0110, 0, 1, 1, -1);
    step(0, 0, 4'b0000, 4'b0110, 0, 1, 1, -1);
    step(0, 0, 4'b0000, 4'b0110, 1, 1, 1, -1);
    step(0, 0, 4'b0000, 4'b0110, 0, 2, 1, -1);
    // wrap
    step(0, 0, 4'b0000, 4'b0110, 1, 2, 1, -1);
    step(0, 0, 4'b0000, 4'b0011, 1, 0, 0, -1);
    step(0, 0, 4'b0000, 4'b0011, 0, 1, 0, -1);
    step(0, 0, 4'b0000, 4'b0000, 1, 0, 0, -1);
    // flush beats handshake
    step(0, 0, 4'b0000, 4'b0010, 1, 1, 1, -1);
    step(0, 1, 4'b0000, 4'b0100, 1, 2, 2, -1);
    step(0, 0, 4'b0000, 4'b1111, 0, 0, 0, -1);
    // reset beats flush and handshake
    step(0, 0, 4'b0000, 4'b1111, 1, 0, 0, -1);
    step(1, 1, 4'b0000, 4'b0010, 1, 1, 1, -1);
    step(0, 0, 4'b0000, 4'b1111, 0, 0, 0, -1);
    // fixed priority holds under handshakes
    step(0, 0, 4'b0000, 4'b1100, 1, 2, 2, -1);
    step(0, 0, 4'b0000, 4'b1100, 1, 3, 2, -1);
    step(0, 0, 4'b0000, 4'b1100, 1, 2, 2, -1);
    step(0, 0, 4'b0000, 4'b1000, 1, 3, 3, -1);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 31) == 0,
           $urandom_range(0, 15) == 0,
           N'($urandom), N'($urandom),
           1'($urandom), -1, -1, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
